// File: rtl/or_stim_pkg.sv
// Shared definitions for the OR-gate stimulus generator.
//   - mode encodings for the four pattern families
//   - FSM state type
//   - sweep_len(): number of patterns in one sweep of a mode
//   - pattern():   4-bit pattern {A,B,C,D} for a given mode and index
package or_stim_pkg;

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_GRAY = 2'b01;
    localparam logic [1:0] MODE_WALK = 2'b10;
    localparam logic [1:0] MODE_ONES = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Sweep length is 5 bits wide so that 16 is representable.
    function automatic logic [4:0] sweep_len(input logic [1:0] mode);
        case (mode)
            MODE_BIN:  return 5'd16;
            MODE_GRAY: return 5'd16;
            MODE_WALK: return 5'd4;
            default:   return 5'd1;
        endcase
    endfunction

    function automatic logic [3:0] pattern(input logic [1:0] mode, input logic [3:0] idx);
        case (mode)
            MODE_BIN:  return idx;
            MODE_GRAY: return idx ^ (idx >> 1);
            MODE_WALK: return 4'b0001 << idx[1:0];
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/or_stim_prescaler.sv
// Rate prescaler for the stimulus generator.
// Counts 0..DIV-1 while en is high and wraps; tick is high while the count
// sits at DIV-1 (and en is high), marking the edge at which the next
// pattern is applied. clear forces the count back to 0.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  synchronous count clear (has priority over en)
//   en     in  count enable
//   tick   out high during the last cycle of each DIV-cycle period
module or_stim_prescaler #(
    parameter int DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int         W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) count <= '0;
            else               count <= count + 1'b1;
        end
    end

    // With DIV=1 the count is pinned at 0 and tick stays high throughout.
    assign tick = en && (count == LAST);

endmodule

// File: rtl/or_stimulus_gen.sv
// Clocked 4-bit pattern generator driving the A/B/C/D inputs of the
// four-input OR gate stage. Sweeps a selectable pattern family at one
// pattern per DIV clocks, with restartable start/stop control.
//   clk, rst_n  in  clock, asynchronous active-low reset
//   start       in  begin sweep (honoured only in IDLE, and only if stop=0)
//   stop        in  abort sweep (RUN) / block start (IDLE)
//   mode[1:0]   in  pattern family, captured at start
//   loop        in  repeat sweep; sampled at the end of each sweep
//   A,B,C,D     out pattern bits, A = MSB
//   step        out one-cycle pulse whenever a new pattern index is applied
//   busy        out high while sweeping
//   done        out one-cycle pulse when a non-looping sweep completes
module or_stimulus_gen
    import or_stim_pkg::*;
#(
    parameter int DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic       loop,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       step,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nx;
    logic [1:0] mode_q, mode_nx;
    logic [3:0] idx_q, idx_nx;
    logic [3:0] pat_q, pat_nx;
    logic       step_q, step_nx;
    logic       tick;
    logic       last_idx;

    or_stim_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != RUN),
        .en    (state == RUN),
        .tick  (tick)
    );

    assign last_idx = ({1'b0, idx_q} == (sweep_len(mode_q) - 5'd1));

    // NOTE: every signal written below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        mode_nx  = mode_q;
        idx_nx   = idx_q;
        pat_nx   = pat_q;
        step_nx  = 1'b0;
        case (state)
            IDLE: begin
                pat_nx = 4'b0000;
                if (start && !stop) begin
                    state_nx = RUN;
                    mode_nx  = mode;
                    idx_nx   = 4'd0;
                    pat_nx   = pattern(mode, 4'd0);
                    step_nx  = 1'b1;
                end
            end
            RUN: begin
                // stop wins over a coincident advance or end of sweep.
                if (stop) begin
                    state_nx = IDLE;
                    idx_nx   = 4'd0;
                    pat_nx   = 4'b0000;
                end else if (tick) begin
                    if (!last_idx) begin
                        idx_nx  = idx_q + 4'd1;
                        pat_nx  = pattern(mode_q, idx_q + 4'd1);
                        step_nx = 1'b1;
                    end else if (loop) begin
                        idx_nx  = 4'd0;
                        pat_nx  = pattern(mode_q, 4'd0);
                        step_nx = 1'b1;
                    end else begin
                        // Last pattern stays on the pins through DONE.
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                idx_nx   = 4'd0;
                pat_nx   = 4'b0000;
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = 4'd0;
                pat_nx   = 4'b0000;
            end
        endcase
    end

    // NOTE: only control/datapath flops exist here (no memories), and all of
    // them are reset so outputs clear immediately on rst_n, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_q <= MODE_BIN;
            idx_q  <= 4'd0;
            pat_q  <= 4'b0000;
            step_q <= 1'b0;
        end else begin
            state  <= state_nx;
            mode_q <= mode_nx;
            idx_q  <= idx_nx;
            pat_q  <= pat_nx;
            step_q <= step_nx;
        end
    end

    assign {A, B, C, D} = pat_q;
    assign step         = step_q;
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_or_stimulus_gen.sv
// Self-checking bench for or_stimulus_gen. Three instances (DIV = 4, 2, 1)
// share the same stimulus; each is compared every cycle against a
// behavioural model that derives the expected pattern from elapsed cycles
// since start (index = elapsed / DIV) rather than from a prescaler/FSM.
module tb_or_stimulus_gen;

    localparam int NI = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       loop  = 1'b0;
    logic [1:0] mode  = 2'b00;

    // {A,B,C,D,step,busy,done} per instance
    logic [6:0] obs [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DV = (g == 0) ? 4 : (g == 1) ? 2 : 1;
        logic a, b, c, d, st, bz, dn;
        or_stimulus_gen #(.DIV(DV)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .stop  (stop),
            .mode  (mode),
            .loop  (loop),
            .A     (a),
            .B     (b),
            .C     (c),
            .D     (d),
            .step  (st),
            .busy  (bz),
            .done  (dn)
        );
        assign obs[g] = {a, b, c, d, st, bz, dn};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 1;
    endfunction

    function automatic int ref_len(input int m);
        case (m)
            0, 1:    return 16;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [3:0] ref_pat(input int m, input int k);
        int v;
        case (m)
            0:       v = k;
            1:       v = k ^ (k / 2);
            2:       v = 1 << (k % 4);
            default: v = 15;
        endcase
        return v[3:0];
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    int         ph    [NI];   // 0 idle, 1 sweeping, 2 done cycle
    int         el    [NI];   // cycles elapsed since the sweep (re)started
    int         mm    [NI];
    logic [6:0] exp_o [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                ph[i] = 0; el[i] = 0; mm[i] = 0; exp_o[i] = '0;
            end else begin
                case (ph[i])
                    0: begin
                        if (start && !stop) begin
                            ph[i] = 1; el[i] = 0; mm[i] = int'(mode);
                            exp_o[i] = {ref_pat(mm[i], 0), 3'b110};
                        end else begin
                            exp_o[i] = '0;
                        end
                    end
                    1: begin
                        if (stop) begin
                            ph[i] = 0; exp_o[i] = '0;
                        end else begin
                            el[i]++;
                            if (el[i] % div_of(i) == 0) begin
                                if (el[i] / div_of(i) < ref_len(mm[i])) begin
                                    exp_o[i] = {ref_pat(mm[i], el[i] / div_of(i)), 3'b110};
                                end else if (loop) begin
                                    el[i] = 0;
                                    exp_o[i] = {ref_pat(mm[i], 0), 3'b110};
                                end else begin
                                    ph[i] = 2;
                                    exp_o[i] = {exp_o[i][6:3], 3'b001};
                                end
                            end else begin
                                exp_o[i] = {exp_o[i][6:3], 3'b010};
                            end
                        end
                    end
                    default: begin
                        ph[i] = 0; exp_o[i] = '0;
                    end
                endcase
            end
        end
        #1;
        for (int i = 0; i < NI; i++)
            check($sformatf("div%0d_outputs", div_of(i)), 32'(obs[i]), 32'(exp_o[i]));
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic [1:0] m, input logic lp);
        @(negedge clk);
        mode = m; loop = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Binary, non-looping: full 16-step sweep then done and 0000.
        pulse_start(2'b00, 1'b0);
        repeat (70) @(negedge clk);

        // Gray, non-looping.
        pulse_start(2'b01, 1'b0);
        repeat (70) @(negedge clk);

        // Walking-one looping, stopped after 11 cycles; mode change mid-run ignored.
        pulse_start(2'b10, 1'b1);
        repeat (4) @(negedge clk);
        mode = 2'b00;
        repeat (6) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (4) @(negedge clk);

        // All-ones, non-looping.
        pulse_start(2'b11, 1'b0);
        repeat (8) @(negedge clk);

        // start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        #2;
        check("start_stop_idle_busy", 32'(obs[0][1]), 32'd0);
        repeat (2) @(negedge clk);

        // Async reset mid-sweep at index 7 of the DIV=4 instance.
        @(negedge clk);
        mode = 2'b00; loop = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        check("pre_reset_index", 32'(obs[0][6:3]), 32'd7);
        check("pre_reset_busy", 32'(obs[0][1]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
            check($sformatf("async_reset_div%0d", div_of(i)), 32'(obs[i]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized control traffic.
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            start = ($urandom % 6) == 0;
            stop  = ($urandom % 25) == 0;
            loop  = ($urandom % 3) != 0;
            mode  = 2'($urandom % 4);
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
